md_sched: RTL and testbench

- Multi-cycle multiply/divide controller for the mips core's execute stage.
- Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO request from the pipeline and holds the HI/LO pair.
- Sequences the arithmetic over a fixed latency and asserts busy so hazard logic can stall later HI/LO users (MFHI/MFLO and further md ops).
- Keeps the rest of the datapath single-cycle while emulating a long-latency resource.

---
 rtl/mips_defs.sv | 21 ++
 rtl/md_calc.sv | 47 ++++
 rtl/md_sched.sv | 109 ++++++++++
 tb/tb_md_sched.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared mips definitions: multiply/divide opcodes, default latencies and
// the md scheduler state type.
package mips_defs;

  localparam logic [2:0] NOP   = 3'd0;
  localparam logic [2:0] MULT  = 3'd1;
  localparam logic [2:0] MULTU = 3'd2;
  localparam logic [2:0] DIV   = 3'd3;
  localparam logic [2:0] DIVU  = 3'd4;
  localparam logic [2:0] MTHI  = 3'd5;
  localparam logic [2:0] MTLO  = 3'd6;

  localparam int unsigned MD_MULT_CYC = 5;
  localparam int unsigned MD_DIV_CYC  = 10;

  typedef enum logic {
    MD_IDLE,
    MD_RUN
  } md_state_t;

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath: latched op and operands to a
// 64-bit {hi,lo} result, with a divide-by-zero flag for DIV/DIVU.
module md_calc
  import mips_defs::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic               ovf;
  logic [31:0]        b_safe;
  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;

  always_comb begin
    // Divisor is steered away from 0 and from the INT_MIN/-1 overflow so the
    // divider never sees an undefined case; both are resolved explicitly below.
    ovf    = (a == 32'h8000_0000) && (b == '1);
    b_safe = ((b == '0) || ovf) ? 32'd1 : b;
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};
    quo_s  = $signed(a) / $signed(b_safe);
    rem_s  = $signed(a) % $signed(b_safe);

    result      = '0;
    div_by_zero = 1'b0;
    case (op)
      MULT:  result = prod_s;
      MULTU: result = prod_u;
      DIV: begin
        div_by_zero = (b == '0);
        result      = ovf ? {32'd0, 32'h8000_0000} : {rem_s, quo_s};
      end
      DIVU: begin
        div_by_zero = (b == '0);
        result      = {a % b_safe, a / b_safe};
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// Multi-cycle multiply/divide controller for the execute stage: latches one
// md request, holds busy for a fixed latency and owns the HI/LO pair.
module md_sched
  import mips_defs::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYC,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_t   state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [2:0]  op_q, op_next;
  logic [31:0] a_q, a_next;
  logic [31:0] b_q, b_next;
  logic [31:0] hi_next, lo_next;
  logic        done_next;
  logic [63:0] result;
  logic        div_by_zero;

  md_calc u_calc (
    .op          (op_q),
    .a           (a_q),
    .b           (b_q),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  assign busy = (state == MD_RUN);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    op_next    = op_q;
    a_next     = a_q;
    b_next     = b_q;
    hi_next    = hi;
    lo_next    = lo;
    done_next  = 1'b0;
    case (state)
      MD_IDLE: begin
        if (start && !flush) begin
          case (op)
            MULT, MULTU, DIV, DIVU: begin
              op_next    = op;
              a_next     = rs_val;
              b_next     = rt_val;
              cnt_next   = ((op == DIV) || (op == DIVU)) ? 4'(DIV_CYCLES - 1)
                                                         : 4'(MULT_CYCLES - 1);
              state_next = MD_RUN;
            end
            MTHI:    hi_next = rs_val;
            MTLO:    lo_next = rs_val;
            default: ;
          endcase
        end
      end
      MD_RUN: begin
        if (flush) begin
          state_next = MD_IDLE;
        end else if (cnt != 4'd0) begin
          cnt_next = cnt - 4'd1;
        end else begin
          state_next = MD_IDLE;
          done_next  = 1'b1;
          if (!div_by_zero) begin
            hi_next = result[63:32];
            lo_next = result[31:0];
          end
        end
      end
      default: state_next = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
      op_q  <= NOP;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      op_q  <= op_next;
      a_q   <= a_next;
      b_q   <= b_next;
      hi    <= hi_next;
      lo    <= lo_next;
      done  <= done_next;
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: deadline-based reference model compared
// every cycle, plus directed literal checks on key transactions.
module tb_md_sched;
  import mips_defs::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = NOP;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;

  md_sched #(.MULT_CYCLES(MD_MULT_CYC), .DIV_CYCLES(MD_DIV_CYC)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference arithmetic straight from the instruction definitions.
  function automatic logic [63:0] md_ref(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    case (o)
      MULT:  res = 64'(sa * sb);
      MULTU: res = {32'd0, a} * {32'd0, b};
      DIV: begin
        q = sa / sb;
        r = sa % sb;
        res = {32'(r), 32'(q)};
      end
      DIVU:  res = {a % b, a / b};
      default: res = '0;
    endcase
    return res;
  endfunction

  // Model: an accepted op completes at an absolute edge number.
  int          edge_n = 0;
  bit          m_run = 1'b0;
  int          m_end = 0;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b;
  logic [31:0] m_hi = '0, m_lo = '0;
  bit          m_done = 1'b0;
  logic [63:0] m_res;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run = 1'b0; m_done = 1'b0; m_hi = '0; m_lo = '0;
    end else begin
      edge_n++;
      m_done = 1'b0;
      if (m_run) begin
        if (flush) m_run = 1'b0;
        else if (edge_n == m_end) begin
          m_run  = 1'b0;
          m_done = 1'b1;
          if (!(((m_op == DIV) || (m_op == DIVU)) && (m_b == 0))) begin
            m_res = md_ref(m_op, m_a, m_b);
            m_hi  = m_res[63:32];
            m_lo  = m_res[31:0];
          end
        end
      end else if (start && !flush) begin
        case (op)
          MULT, MULTU: begin
            m_run = 1'b1; m_end = edge_n + int'(MD_MULT_CYC);
            m_op = op; m_a = rs_val; m_b = rt_val;
          end
          DIV, DIVU: begin
            m_run = 1'b1; m_end = edge_n + int'(MD_DIV_CYC);
            m_op = op; m_a = rs_val; m_b = rt_val;
          end
          MTHI: m_hi = rs_val;
          MTLO: m_lo = rs_val;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      chk("model_busy", {31'd0, busy}, {31'd0, m_run});
      chk("model_done", {31'd0, done}, {31'd0, m_done});
      chk("model_hi", hi, m_hi);
      chk("model_lo", lo, m_lo);
    end
  end

  // Drive a one-cycle request from a negedge; returns at the following negedge
  // with operands scrambled to show they are not re-sampled.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0; op = NOP; rs_val = $urandom; rt_val = $urandom;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(posedge clk); #2 reset = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);

    issue(MULT, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    chk("mult_busy_cycles", n, 32'd5);
    chk("mult_done", {31'd0, done}, 32'd1);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    @(negedge clk);
    chk("mult_done_one_pulse", {31'd0, done}, 32'd0);

    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("multu_busy_cycles", n, 32'd5);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    chk("div_busy_cycles", n, 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'h0000_0000);

    issue(DIVU, 32'd100, 32'd7);
    wait_idle(n);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    issue(MTHI, 32'h11, 32'd0);
    chk("mthi_hi", hi, 32'h11);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    issue(MTLO, 32'h22, 32'd0);
    chk("mtlo_lo", lo, 32'h22);
    chk("mtlo_done", {31'd0, done}, 32'd0);

    issue(DIVU, 32'd5, 32'd0);
    wait_idle(n);
    chk("dbz_busy_cycles", n, 32'd10);
    chk("dbz_done", {31'd0, done}, 32'd1);
    chk("dbz_hi", hi, 32'h11);
    chk("dbz_lo", lo, 32'h22);

    issue(MULT, 32'd7, 32'd9);
    issue(MTLO, 32'h55, 32'd0);
    issue(MULT, 32'd3, 32'd3);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_done", {31'd0, done}, 32'd0);
    repeat (12) begin
      @(negedge clk);
      if (done) chk("flush_no_done", {31'd0, done}, 32'd0);
    end
    chk("flush_hi", hi, 32'h11);
    chk("flush_lo", lo, 32'h22);

    issue(MULT, 32'd6, 32'd7);
    wait_idle(n);
    chk("b2b_first_lo", lo, 32'd42);
    issue(MULT, 32'hFFFF_FFFF, 32'd5);
    chk("b2b_accepted", {31'd0, busy}, 32'd1);
    wait_idle(n);
    chk("b2b_second_hi", hi, 32'hFFFF_FFFF);
    chk("b2b_second_lo", lo, 32'hFFFF_FFFB);

    flush = 1'b1;
    issue(MTHI, 32'h1234, 32'd0);
    flush = 1'b0;
    chk("idle_flush_hi", hi, 32'hFFFF_FFFF);
    issue(NOP, 32'h9999, 32'd1);
    issue(3'd7, 32'h9999, 32'd1);
    chk("nop_busy", {31'd0, busy}, 32'd0);
    chk("nop_lo", lo, 32'hFFFF_FFFB);

    issue(DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    chk("async_rst_hi", hi, 32'd0);
    chk("async_rst_lo", lo, 32'd0);
    @(posedge clk); #2 reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("post_rst_lo", lo, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
